// File: rtl/stack_pkg.sv
// stack_pkg: constants and types shared between the stack logic, the stack
// renderer and the preview renderer.
//   - VGA geometry (visible area, total lines)
//   - block geometry and maximum stack depth
//   - 2-bit colour index to RRRGGGBB palette
//   - line-setup FSM state type
package stack_pkg;

    localparam int H_VISIBLE  = 640;
    localparam int V_VISIBLE  = 480;
    localparam int V_TOTAL    = 525;

    localparam int BLK_W      = 30;
    localparam int BLK_H      = 20;
    localparam int MAX_BLOCKS = 16;

    localparam logic [7:0] PAL_RED    = 8'hE0;
    localparam logic [7:0] PAL_GREEN  = 8'h1C;
    localparam logic [7:0] PAL_BLUE   = 8'h03;
    localparam logic [7:0] PAL_YELLOW = 8'hFC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } setup_state_t;

    function automatic logic [7:0] palette(input logic [1:0] idx);
        logic [7:0] c;
        case (idx)
            2'b00:   c = PAL_RED;
            2'b01:   c = PAL_GREEN;
            2'b10:   c = PAL_BLUE;
            default: c = PAL_YELLOW;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seq_div10.sv
// seq_div10: 10-bit by 5-bit restoring divider, one quotient bit per clock.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load operands and begin (restarts a running divide)
//   dividend      : 10-bit unsigned dividend
//   divisor       : 5-bit unsigned divisor, must be non-zero
//   quot          : quotient, valid from done onwards until the next start
//   done          : one-cycle pulse after the tenth iteration
module seq_div10
    import stack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] dividend,
    input  logic [4:0] divisor,
    output logic [9:0] quot,
    output logic       done
);

    logic [9:0] dvd_q;
    logic [9:0] quot_q;
    logic [4:0] rem_q;
    logic [3:0] cnt_q;
    logic       done_q;

    logic [5:0] rem_sh;
    logic       ge;
    logic [5:0] rem_sub;

    // The remainder is always below the divisor, so 5 bits hold it and the
    // shifted trial value needs only one extra bit.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[9]};
        ge      = (rem_sh >= {1'b0, divisor});
        rem_sub = rem_sh - {1'b0, divisor};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            dvd_q  <= dividend;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= 4'd10;
            done_q <= 1'b0;
        end else if (cnt_q != 4'd0) begin
            dvd_q  <= {dvd_q[8:0], 1'b0};
            rem_q  <= ge ? rem_sub[4:0] : rem_sh[4:0];
            quot_q <= {quot_q[8:0], ge};
            cnt_q  <= cnt_q - 4'd1;
            done_q <= (cnt_q == 4'd1);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign quot = quot_q;
    assign done = done_q;

endmodule

// File: rtl/stack_renderer.sv
// stack_renderer: pixel-side renderer for the block stack.
// Snapshots the stack state once per frame (start of vertical blank), works
// out during each horizontal blank which block covers the next scanline, and
// emits a registered RRRGGGBB colour plus hit flag for every pixel enable.
//   clk, rst      : 100 MHz clock, asynchronous active-low reset
//   pix_en        : pixel-clock enable (one clk in four)
//   hc, vc        : current pixel column / scanline
//   video_on      : current pixel is in the visible area
//   pos_x, pos_y  : stack left edge / line just below the bottom block
//   height        : number of blocks (clamped to MAX_BLOCKS on snapshot)
//   colors        : 2-bit colour index per block, block 0 in the low bits
//   rgb, hit      : registered pixel colour and inside-a-block flag
module stack_renderer
    import stack_pkg::*;
#(
    parameter int         BLK_W      = stack_pkg::BLK_W,
    parameter int         BLK_H      = stack_pkg::BLK_H,
    parameter int         MAX_BLOCKS = stack_pkg::MAX_BLOCKS,
    parameter int         H_VISIBLE  = stack_pkg::H_VISIBLE,
    parameter int         V_VISIBLE  = stack_pkg::V_VISIBLE,
    parameter int         V_TOTAL    = stack_pkg::V_TOTAL,
    parameter logic [7:0] BG_RGB     = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pix_en,
    input  logic [9:0]                hc,
    input  logic [9:0]                vc,
    input  logic                      video_on,
    input  logic [9:0]                pos_x,
    input  logic [9:0]                pos_y,
    input  logic [9:0]                height,
    input  logic [2*MAX_BLOCKS-1:0]   colors,
    output logic [7:0]                rgb,
    output logic                      hit
);

    localparam int HW = $clog2(MAX_BLOCKS + 1);
    localparam int IW = $clog2(MAX_BLOCKS);

    // ---------------- frame snapshot ----------------
    logic [9:0]              pos_x_s;
    logic [9:0]              pos_y_s;
    logic [HW-1:0]           height_s;
    logic [2*MAX_BLOCKS-1:0] colors_s;

    logic snap_trig;
    assign snap_trig = pix_en && (hc == 10'd0) && (vc == 10'(V_VISIBLE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x_s  <= '0;
            pos_y_s  <= '0;
            height_s <= '0;
            colors_s <= '0;
        end else if (snap_trig) begin
            pos_x_s  <= pos_x;
            pos_y_s  <= pos_y;
            height_s <= (height > 10'(MAX_BLOCKS)) ? HW'(MAX_BLOCKS) : height[HW-1:0];
            colors_s <= colors;
        end
    end

    // ---------------- line setup ----------------
    logic              setup_trig;
    logic [9:0]        nv;
    logic signed [10:0] d;

    assign setup_trig = pix_en && (hc == 10'(H_VISIBLE));
    assign nv         = (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
    // Distance in lines from the bottom block's last line up to the target
    // line; negative means the target is below the stack.
    assign d          = $signed({1'b0, pos_y_s}) - $signed({1'b0, nv}) - 11'sd1;

    setup_state_t state_q, state_n;
    logic         div_start;
    logic         div_done;
    logic [9:0]   quot;
    logic         line_empty;
    logic         row_valid;
    logic [1:0]   row_col;
    logic [IW-1:0] blk_idx;

    seq_div10 u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (d[9:0]),
        .divisor  (5'(BLK_H)),
        .quot     (quot),
        .done     (div_done)
    );

    // A trigger wins over any in-flight setup: the divider is simply
    // reloaded and the stale result never reaches the row registers.
    always_comb begin
        state_n   = state_q;
        div_start = 1'b0;
        if (setup_trig) begin
            if (d[10]) begin
                state_n = ST_DONE;
            end else begin
                state_n   = ST_DIV;
                div_start = 1'b1;
            end
        end else begin
            case (state_q)
                ST_DIV:  if (div_done) state_n = ST_DONE;
                ST_DONE: state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_n;
    end

    assign blk_idx = quot[IW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_empty <= 1'b1;
            row_valid  <= 1'b0;
            row_col    <= 2'b00;
        end else begin
            if (setup_trig)
                line_empty <= d[10];
            // Row registers change only here so the visible line never sees a
            // half-updated block selection.
            if (state_q == ST_DONE) begin
                row_valid <= !line_empty && (quot < 10'(height_s));
                row_col   <= colors_s[{blk_idx, 1'b0} +: 2];
            end
        end
    end

    // ---------------- pixel stage ----------------
    logic [10:0] hc_x, x_lo, x_hi;
    logic        hit_n;

    // 11-bit so a stack near the right edge cannot wrap its right bound.
    always_comb begin
        hc_x  = {1'b0, hc};
        x_lo  = {1'b0, pos_x_s};
        x_hi  = x_lo + 11'(BLK_W);
        hit_n = video_on && row_valid && (hc_x >= x_lo) && (hc_x < x_hi);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb <= BG_RGB;
            hit <= 1'b0;
        end else if (pix_en) begin
            hit <= hit_n;
            rgb <= hit_n ? palette(row_col) : BG_RGB;
        end
    end

endmodule
